// File: rtl/rggen_register_host_adapter.sv
// Host-side sequencer: one valid/ready request channel drives a broadcast register bus.
// Define RGGEN_REGISTER_HOST_ADAPTER_TIMEOUT_EN to enable the ACCESS-state timeout counter.
module rggen_register_host_adapter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int REGISTERS     = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_request_valid,
    output logic                           o_request_ready,
    input  logic                           i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_request_address,
    input  logic [BUS_WIDTH-1:0]           i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_request_strobe,
    output logic                           o_response_valid,
    input  logic                           i_response_ready,
    output logic [1:0]                     o_response_status,
    output logic [BUS_WIDTH-1:0]           o_response_read_data,
    output logic                           o_register_valid,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic                           o_register_write,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data,
    input  logic [REGISTERS-1:0]           i_register_active
);

    typedef enum logic [1:0] {StIdle, StAccess, StResponse} state_e;

    state_e                   state_q, state_d;
    logic                     request_ready_q;
    logic                     register_valid_q;
    logic                     response_valid_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic                     write_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [BUS_WIDTH/8-1:0]   strobe_q;
    logic [1:0]               status_q, status_d;
    logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;

    logic                     any_ready;
    logic                     any_active;
    logic [1:0]               ready_status;
    logic [BUS_WIDTH-1:0]     ready_data;
    logic                     timeout;
    logic                     accept;

    assign accept = (state_q == StIdle) && i_request_valid && request_ready_q;

    // Descending scan so the lowest-index ready register supplies the status.
    always_comb begin
        any_ready    = |i_register_ready;
        any_active   = |i_register_active;
        ready_status = 2'b00;
        ready_data   = '0;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if (i_register_ready[i]) begin
                ready_status = i_register_status[2*i+:2];
                ready_data   = ready_data | i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
            end
        end
    end

`ifdef RGGEN_REGISTER_HOST_ADAPTER_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT + 1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + COUNT_WIDTH'(1);
        timeout = (count_d == COUNT_WIDTH'(TIMEOUT));
    end

    // Held at zero outside ACCESS, so every access starts from a cleared count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || state_q != StAccess) begin
            count_q <= '0;
        end else if (!any_ready && any_active) begin
            count_q <= count_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        read_data_d = read_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (any_ready) begin
                    state_d     = StResponse;
                    status_d    = ready_status;
                    read_data_d = write_q ? '0 : ready_data;
                end else if (!any_active) begin
                    state_d     = StResponse;
                    status_d    = 2'b11;
                    read_data_d = '0;
                end else if (timeout) begin
                    state_d     = StResponse;
                    status_d    = 2'b10;
                    read_data_d = '0;
                end
            end
            StResponse: begin
                if (i_response_ready) begin
                    state_d     = StIdle;
                    status_d    = 2'b00;
                    read_data_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= StIdle;
            request_ready_q  <= 1'b0;
            register_valid_q <= 1'b0;
            response_valid_q <= 1'b0;
            address_q        <= '0;
            write_q          <= 1'b0;
            write_data_q     <= '0;
            strobe_q         <= '0;
            status_q         <= 2'b00;
            read_data_q      <= '0;
        end else begin
            state_q          <= state_d;
            request_ready_q  <= (state_d == StIdle);
            register_valid_q <= (state_d == StAccess);
            response_valid_q <= (state_d == StResponse);
            status_q         <= status_d;
            read_data_q      <= read_data_d;
            if (accept) begin
                address_q    <= i_request_address;
                write_q      <= i_request_write;
                write_data_q <= i_request_write_data;
                strobe_q     <= i_request_strobe;
            end
        end
    end

    assign o_request_ready       = request_ready_q;
    assign o_register_valid      = register_valid_q;
    assign o_register_address    = address_q;
    assign o_register_write      = write_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;
    assign o_response_valid      = response_valid_q;
    assign o_response_status     = status_q;
    assign o_response_read_data  = read_data_q;

endmodule
